mem_arbiter: RTL and testbench

- Shares the single RAM port between the instruction-fetch requester and the data-memory requester of the pipelined datapath.
- Sequences each RAM transaction with a grant-lock FSM: a grant is held until RAM signals ACCESS or the requester withdraws.
- Data requests win by default; an instruction-starvation counter bounds fetch latency under data-heavy code.

---
 rtl/cpu_types_pkg.sv | 15 +
 rtl/mem_arbiter.sv | 109 ++++++++++
 tb/tb_mem_arbiter.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// Types shared across the CPU datapath: RAM handshake states and the machine word.
package cpu_types_pkg;

    localparam int WORD_BITS = 32;

    typedef logic [WORD_BITS-1:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

endpackage

// File: rtl/mem_arbiter.sv
// Shares one RAM port between instruction fetch and data access; data wins by
// default, with a starvation counter that forces a fetch grant after STARVE_MAX data grants.
module mem_arbiter
    import cpu_types_pkg::*;
#(
    parameter int WORD_W     = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              iREN,
    input  logic [WORD_W-1:0] iaddr,
    output logic [WORD_W-1:0] iload,
    output logic              iwait,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [WORD_W-1:0] daddr,
    input  logic [WORD_W-1:0] dstore,
    output logic [WORD_W-1:0] dload,
    output logic              dwait,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [WORD_W-1:0] ramaddr,
    output logic [WORD_W-1:0] ramstore,
    input  logic [WORD_W-1:0] ramload,
    input  logic [1:0]        ramstate,
    output logic [1:0]        arb_state,
    output logic [3:0]        starve_cnt
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2
    } arb_state_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    arb_state_t state;
    ramstate_t  ram_st;
    logic       d_req;
    logic       ram_done;

    assign ram_st   = ramstate_t'(ramstate);
    assign d_req    = dREN | dWEN;
    assign ram_done = (ram_st == ACCESS);

    // Grant is held through BUSY/FREE/ERROR; only completion or withdrawal releases it.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state      <= IDLE;
            starve_cnt <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (iREN && (starve_cnt == STARVE_LIM)) begin
                        state      <= GRANT_I;
                        starve_cnt <= 4'd0;
                    end else if (d_req) begin
                        state <= GRANT_D;
                        if (iREN && (starve_cnt < STARVE_LIM))
                            starve_cnt <= starve_cnt + 4'd1;
                    end else if (iREN) begin
                        state      <= GRANT_I;
                        starve_cnt <= 4'd0;
                    end
                end
                GRANT_D: begin
                    if (ram_done || !d_req)
                        state <= IDLE;
                end
                GRANT_I: begin
                    if (ram_done || !iREN)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        iwait    = 1'b1;
        dwait    = 1'b1;
        case (state)
            GRANT_D: begin
                ramREN   = dREN;
                ramWEN   = dWEN;
                ramaddr  = daddr;
                ramstore = dstore;
                dwait    = !ram_done;
            end
            GRANT_I: begin
                ramREN  = iREN;
                ramaddr = iaddr;
                iwait   = !ram_done;
            end
            default: ;
        endcase
    end

    assign iload     = ramload;
    assign dload     = ramload;
    assign arb_state = state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reset, fetch, priority, starvation, withdrawal, error retry.
module tb_mem_arbiter;
    import cpu_types_pkg::*;

    localparam int W = 32;
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_GI   = 2'd1;
    localparam logic [1:0] S_GD   = 2'd2;

    logic         CLK = 1'b0;
    logic         nRST;
    logic         iREN, dREN, dWEN;
    logic [W-1:0] iaddr, daddr, dstore, ramload;
    logic [W-1:0] iload, dload, ramaddr, ramstore;
    logic         iwait, dwait, ramREN, ramWEN;
    logic [1:0]   ramstate;
    logic [1:0]   arb_state;
    logic [3:0]   starve_cnt;

    int vectors     = 0;
    int miscompares = 0;

    always #5 CLK = ~CLK;

    mem_arbiter #(.WORD_W(W), .STARVE_MAX(4)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dload(dload), .dwait(dwait),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
        .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate),
        .arb_state(arb_state), .starve_cnt(starve_cnt)
    );

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge, then let combinational outputs settle after input changes.
    task automatic next_cycle();
        @(posedge CLK);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        nRST = 1'b0; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
        iaddr = '0; daddr = '0; dstore = '0; ramload = '0; ramstate = FREE;

        // Reset held with a pending fetch
        iREN = 1'b1; iaddr = 32'h100;
        repeat (2) next_cycle();
        check("rst_ramREN", ramREN, 0);
        check("rst_ramWEN", ramWEN, 0);
        check("rst_iwait", iwait, 1);
        check("rst_dwait", dwait, 1);
        check("rst_ramaddr", ramaddr, 0);
        check("rst_state", arb_state, S_IDLE);
        check("rst_starve", starve_cnt, 0);
        nRST = 1'b1;
        settle();
        check("post_rst_idle_ramREN", ramREN, 0);
        next_cycle();
        check("gi_ramREN", ramREN, 1);
        check("gi_ramaddr", ramaddr, 32'h100);
        check("gi_state", arb_state, S_GI);

        // Lone fetch: two BUSY cycles then ACCESS
        ramstate = BUSY; settle();
        check("fetch_busy1_iwait", iwait, 1);
        next_cycle();
        check("fetch_busy2_iwait", iwait, 1);
        check("fetch_busy2_ramREN", ramREN, 1);
        next_cycle();
        ramstate = ACCESS; ramload = 32'hDEADBEEF; settle();
        check("fetch_acc_iwait", iwait, 0);
        check("fetch_acc_iload", iload, 32'hDEADBEEF);
        check("fetch_acc_dwait", dwait, 1);
        next_cycle();
        iREN = 1'b0; ramstate = FREE; settle();
        check("fetch_done_state", arb_state, S_IDLE);
        check("fetch_done_iwait", iwait, 1);
        check("fetch_done_ramREN", ramREN, 0);
        next_cycle();

        // Simultaneous fetch and data write: data first
        iREN = 1'b1; iaddr = 32'h104; dWEN = 1'b1; daddr = 32'h200; dstore = 32'h55; settle();
        check("sim_idle_ramWEN", ramWEN, 0);
        next_cycle();
        check("sim_gd_state", arb_state, S_GD);
        check("sim_gd_ramWEN", ramWEN, 1);
        check("sim_gd_ramREN", ramREN, 0);
        check("sim_gd_ramaddr", ramaddr, 32'h200);
        check("sim_gd_ramstore", ramstore, 32'h55);
        check("sim_gd_iwait", iwait, 1);
        check("sim_gd_starve", starve_cnt, 1);
        ramstate = ACCESS; settle();
        check("sim_gd_acc_dwait", dwait, 0);
        next_cycle();
        dWEN = 1'b0; ramstate = FREE; settle();
        check("sim_idle2_state", arb_state, S_IDLE);
        next_cycle();
        check("sim_gi_state", arb_state, S_GI);
        check("sim_gi_ramaddr", ramaddr, 32'h104);
        check("sim_gi_ramstore", ramstore, 0);
        check("sim_gi_starve", starve_cnt, 0);
        ramstate = ACCESS; ramload = 32'h1234; settle();
        check("sim_gi_iwait", iwait, 0);
        next_cycle();
        iREN = 1'b0; ramstate = FREE;

        // Starvation: data re-requests continuously while a fetch waits
        iREN = 1'b1; iaddr = 32'h108; dREN = 1'b1; daddr = 32'h300; settle();
        for (int k = 1; k <= 4; k++) begin
            next_cycle();
            check($sformatf("starve_gd%0d_state", k), arb_state, S_GD);
            check($sformatf("starve_gd%0d_cnt", k), starve_cnt, k);
            check($sformatf("starve_gd%0d_ramaddr", k), ramaddr, 32'h300);
            ramstate = ACCESS; ramload = 32'hA000 + k; settle();
            check($sformatf("starve_gd%0d_dload", k), dload, 32'hA000 + k);
            check($sformatf("starve_gd%0d_dwait", k), dwait, 0);
            next_cycle();
            ramstate = FREE; settle();
            check($sformatf("starve_idle%0d_state", k), arb_state, S_IDLE);
        end
        next_cycle();
        check("starve_forced_gi_state", arb_state, S_GI);
        check("starve_forced_gi_cnt", starve_cnt, 0);
        check("starve_forced_gi_ramaddr", ramaddr, 32'h108);
        check("starve_forced_gi_dwait", dwait, 1);
        ramstate = ACCESS; settle();
        check("starve_forced_gi_iwait", iwait, 0);
        next_cycle();
        iREN = 1'b0; ramstate = FREE;
        next_cycle();
        check("wd_gd_state", arb_state, S_GD);
        check("wd_gd_cnt_no_fetch", starve_cnt, 0);

        // Withdrawal of a data read while BUSY, with a fetch pending
        iREN = 1'b1; iaddr = 32'h10C; ramstate = BUSY; settle();
        check("wd_busy_ramREN", ramREN, 1);
        check("wd_busy_dwait", dwait, 1);
        next_cycle();
        dREN = 1'b0; settle();
        check("wd_drop_ramREN", ramREN, 0);
        check("wd_drop_dwait", dwait, 1);
        check("wd_drop_iwait", iwait, 1);
        next_cycle();
        check("wd_idle_state", arb_state, S_IDLE);
        next_cycle();
        check("wd_gi_state", arb_state, S_GI);
        check("wd_gi_ramaddr", ramaddr, 32'h10C);

        // ERROR retry during a fetch grant
        ramstate = ERROR;
        for (int k = 1; k <= 3; k++) begin
            settle();
            check($sformatf("err%0d_ramREN", k), ramREN, 1);
            check($sformatf("err%0d_iwait", k), iwait, 1);
            check($sformatf("err%0d_state", k), arb_state, S_GI);
            next_cycle();
        end
        ramstate = ACCESS; ramload = 32'hCAFEF00D; settle();
        check("err_acc_ramREN", ramREN, 1);
        check("err_acc_iwait", iwait, 0);
        check("err_acc_iload", iload, 32'hCAFEF00D);
        next_cycle();
        iREN = 1'b0; ramstate = FREE; settle();
        check("err_done_state", arb_state, S_IDLE);

        // Reset in the middle of a data write drops strobes at once
        dWEN = 1'b1; daddr = 32'h400; dstore = 32'h77;
        next_cycle();
        check("mid_gd_ramWEN", ramWEN, 1);
        nRST = 1'b0; settle();
        check("mid_rst_ramWEN", ramWEN, 0);
        check("mid_rst_ramaddr", ramaddr, 0);
        check("mid_rst_ramstore", ramstore, 0);
        check("mid_rst_state", arb_state, S_IDLE);
        dWEN = 1'b0;
        next_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
